multicycle_sequencer: RTL
=========================

# multicycle_sequencer

Parametrised multicycle control sequencer: the next-generation control FSM for the multicycle datapath. It walks each instruction through fetch, decode and execute states, and adds five things to the basic state walk: an asynchronous reset, a pipeline stall input, a memory ready handshake, an instruction-retire counter, and a sticky trap state for illegal opcodes and memory timeouts. Its `state` output drives the datapath control-signal decoder.

## Interface
- `STATE_W`, default 4: width of `state`; must be ≥4; upper bits are zero for all legal states.
- `RETIRE_W`, default 16: width of the retired-instruction counter.
- `TIMEOUT_CYCLES`, default 16: memory-wait limit, ≥2; used only when the watchdog is compiled in.
- `clk` in 1: the single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: opcode from the instruction register; stable from REGISTER_FETCH through MEMORY_REF3.
- `stall` in 1: holds the current state while high.
- `mem_ready` in 1: memory access complete in this cycle.
- `state` out STATE_W: current control state.
- `instr_done` out 1: one-cycle retire pulse.
- `retired` out RETIRE_W: count of completed instructions; wraps.
- `trap` out 1: sticky; high while in TRAP.
- `trap_cause` out 2: 01 = illegal opcode, 10 = memory timeout, 11 = invalid state; 00 while not trapped.

## Operation
- State encodings:
  - IF=0, RF=1, ALU_R3=2, ALU_RI3=3, ALU4=4, BRANCH3=5, MEM3=6
  - LOAD4=7, LOAD5=8, STORE4=9, JUMP3=10, IMM3=11, TRAP=12
- Decode in RF uses opcode[5:3]:
  - 00x → ALU_R3
  - 01x → ALU_RI3
  - 100 → BRANCH3
  - 101 → MEM3
  - 110 → JUMP3, legal only if opcode==6'b110000
  - 111 → IMM3, legal only if opcode==6'b111000
  - any other opcode → TRAP, cause 01.
- Transitions:
  - IF→RF
  - ALU_R3/ALU_RI3→ALU4
  - MEM3 goes to LOAD4 if opcode[2]=0, to STORE4 if opcode[2]=1
  - LOAD4→LOAD5
  - ALU4, BRANCH3, LOAD5, STORE4, JUMP3, IMM3 are terminal: each → IF.
- Memory states are IF, LOAD4, STORE4. They advance only on an edge where `mem_ready`=1; otherwise they hold.
- Stall and trap:
  - `stall`=1 holds any non-TRAP state and freezes the wait counter. Stall takes priority over `mem_ready`.
  - TRAP is absorbing: only `rst_n` leaves it, and `stall` is ignored there.
  - An encoding 13..2^STATE_W−1 goes to TRAP with cause 11 on the next edge.
- Retire:
  - A terminal→IF transition sets `instr_done`=1 for the following cycle and increments `retired` by 1 modulo 2^RETIRE_W on that same edge.
  - A trapped instruction never retires.

## Timing
- Reset: asserting `rst_n`=0 forces all of the following immediately, regardless of `clk`, including mid-instruction or mid-wait:
  - `state`=IF, `instr_done`=0, `retired`=0, `trap`=0, `trap_cause`=00
  - wait counter = 0.
- After reset deassertion, the first state change is at the first rising edge.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Unstalled instruction latency with `mem_ready` tied high:
  - ALU: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch, jump, LDI: 3 cycles.
- Each low-`mem_ready` cycle in a memory state adds one cycle.
- `trap` and `trap_cause` become valid in the first cycle `state`==TRAP.
- Simultaneous events:
  - `stall` with `mem_ready` gives a hold.
  - `stall` with an illegal opcode in RF gives a hold; the trap is taken on the first unstalled edge.

## Configuration
- `CONTROL_TIMEOUT_EN` defined:
  - The wait counter counts consecutive unstalled cycles spent in a memory state with `mem_ready`=0.
  - It clears on any state change.
  - If `mem_ready` is still 0 in the TIMEOUT_CYCLES-th such cycle, the next edge enters TRAP with cause 10.
- Not defined:
  - Memory states wait indefinitely.
  - Cause 10 is never produced, and the counter logic is absent.

## Test plan
- Reset mid-instruction: `rst_n` low while in LOAD4 → `state`=0 immediately, `retired`=0, `trap`=0.
- ALU instruction: `mem_ready`=1, opcode 6'b000011, no stall → `state` sequence 0,1,2,4,0; `instr_done` high one cycle; `retired`=1.
- Load with memory wait: opcode 6'b101000, `mem_ready` low for 3 cycles in LOAD4 → `state` sequence 0,1,6,7,7,7,7,8,0; `retired` +1.
- Stall precedence: `stall`=1 for 2 cycles in STORE4 with `mem_ready`=1 → STORE4 held 2 extra cycles, then →0.
- Illegal opcode: opcode 6'b110001 reaches RF → `state`=12, `trap`=1, `trap_cause`=01; stays there for 20 cycles whatever the inputs; `retired` unchanged.
- Watchdog (`CONTROL_TIMEOUT_EN`, TIMEOUT_CYCLES=16): `mem_ready`=0 held in IF → TRAP, cause 10, on the 16th edge. Without the macro, IF is still held after 100 cycles.

Source files
------------

// File: rtl/multicycle_sequencer_if.sv
// Control bus between the multicycle sequencer and its datapath/control decoder.
interface multicycle_sequencer_if #(
    parameter int STATE_W  = 4,
    parameter int RETIRE_W = 16
);
    logic [5:0]          opcode;
    logic                stall;
    logic                mem_ready;
    logic [STATE_W-1:0]  state;
    logic                instr_done;
    logic [RETIRE_W-1:0] retired;
    logic                trap;
    logic [1:0]          trap_cause;

    modport master (
        output opcode, stall, mem_ready,
        input  state, instr_done, retired, trap, trap_cause
    );
    modport slave (
        input  opcode, stall, mem_ready,
        output state, instr_done, retired, trap, trap_cause
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM with stall, memory handshake, retire counter and sticky trap.
// Define CONTROL_TIMEOUT_EN to compile in the memory-wait watchdog (trap cause 10).
module multicycle_sequencer #(
    parameter int STATE_W        = 4,
    parameter int RETIRE_W       = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_sequencer_if.slave   bus
);
    typedef enum logic [3:0] {
        S_IF = 4'd0, S_RF = 4'd1, S_ALU_R3 = 4'd2, S_ALU_RI3 = 4'd3, S_ALU4 = 4'd4,
        S_BRANCH3 = 4'd5, S_MEM3 = 4'd6, S_LOAD4 = 4'd7, S_LOAD5 = 4'd8,
        S_STORE4 = 4'd9, S_JUMP3 = 4'd10, S_IMM3 = 4'd11, S_TRAP = 4'd12
    } state_e;

    logic [STATE_W-1:0]  state_q, state_d;
    logic                instr_done_q, done_d;
    logic [RETIRE_W-1:0] retired_q;
    logic                trap_q, trap_d;
    logic [1:0]          cause_q, cause_d;
    logic                legal, is_mem, waiting;
    state_e              cur;

    assign legal   = (state_q <= STATE_W'(S_TRAP));
    assign cur     = state_e'(state_q[3:0]);
    assign is_mem  = legal && (cur == S_IF || cur == S_LOAD4 || cur == S_STORE4);
    assign waiting = is_mem && !bus.stall && !bus.mem_ready;

`ifdef CONTROL_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout;
    assign timeout = waiting && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        done_d  = 1'b0;
        if (!legal) begin
            state_d = STATE_W'(S_TRAP);
            cause_d = 2'b11;
        end else if (cur != S_TRAP && !bus.stall) begin
            unique case (cur)
                S_IF:                state_d = bus.mem_ready ? STATE_W'(S_RF) : state_q;
                S_RF: begin
                    unique case (bus.opcode[5:3])
                        3'b000, 3'b001: state_d = STATE_W'(S_ALU_R3);
                        3'b010, 3'b011: state_d = STATE_W'(S_ALU_RI3);
                        3'b100:         state_d = STATE_W'(S_BRANCH3);
                        3'b101:         state_d = STATE_W'(S_MEM3);
                        3'b110:         state_d = (bus.opcode == 6'b110000) ? STATE_W'(S_JUMP3) : STATE_W'(S_TRAP);
                        default:        state_d = (bus.opcode == 6'b111000) ? STATE_W'(S_IMM3) : STATE_W'(S_TRAP);
                    endcase
                    if (state_d == STATE_W'(S_TRAP)) cause_d = 2'b01;
                end
                S_ALU_R3, S_ALU_RI3: state_d = STATE_W'(S_ALU4);
                S_MEM3:              state_d = bus.opcode[2] ? STATE_W'(S_STORE4) : STATE_W'(S_LOAD4);
                S_LOAD4:             state_d = bus.mem_ready ? STATE_W'(S_LOAD5) : state_q;
                S_STORE4: begin
                    state_d = bus.mem_ready ? STATE_W'(S_IF) : state_q;
                    done_d  = bus.mem_ready;
                end
                S_ALU4, S_BRANCH3, S_LOAD5, S_JUMP3, S_IMM3: begin
                    state_d = STATE_W'(S_IF);
                    done_d  = 1'b1;
                end
                default: state_d = state_q;
            endcase
`ifdef CONTROL_TIMEOUT_EN
            if (timeout) begin
                state_d = STATE_W'(S_TRAP);
                cause_d = 2'b10;
                done_d  = 1'b0;
            end
`endif
        end
        trap_d = (state_d == STATE_W'(S_TRAP));
    end

`ifdef CONTROL_TIMEOUT_EN
    // Counter freezes under stall and restarts whenever the state moves.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q)  wait_d = '0;
        else if (waiting)        wait_d = wait_q + WAIT_W'(1);
        else if (!bus.stall)     wait_d = '0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= STATE_W'(S_IF);
            instr_done_q <= 1'b0;
            retired_q    <= '0;
            trap_q       <= 1'b0;
            cause_q      <= 2'b00;
`ifdef CONTROL_TIMEOUT_EN
            wait_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            instr_done_q <= done_d;
            if (done_d) retired_q <= retired_q + RETIRE_W'(1);
            trap_q       <= trap_d;
            cause_q      <= cause_d;
`ifdef CONTROL_TIMEOUT_EN
            wait_q       <= wait_d;
`endif
        end
    end

    assign bus.state      = state_q;
    assign bus.instr_done = instr_done_q;
    assign bus.retired    = retired_q;
    assign bus.trap       = trap_q;
    assign bus.trap_cause = cause_q;
endmodule
